mem_access_unit: RTL and testbench

- Parametrised successor to the current pass-through MEM stage of the 5-stage pipeline; sits between EX/MEM and MEM/WB.
- Executes load/store instructions over a request/acknowledge data bus.
- Generates byte enables, and sign- or zero-extends load data.
- Stalls the pipeline while the bus is busy, aborts on bus timeout, and registers the writeback triple (wd/wreg/wdata) toward WB.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 58 +++++
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM stage: memory op codes, FSM states and
// lane/alignment predicates.
package mem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LBU      = 4'd2,
        LH       = 4'd3,
        LHU      = 4'd4,
        LW       = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } mem_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    // Codes 9..15 are not memory ops and behave like MEM_NONE.
    function automatic logic is_mem(input logic [3:0] op);
        return (op >= 4'(LB)) && (op <= 4'(SW));
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == 4'(SB)) || (op == 4'(SH)) || (op == 4'(SW));
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        logic half_op;
        logic word_op;
        half_op = (op == 4'(LH)) || (op == 4'(LHU)) || (op == 4'(SH));
        word_op = (op == 4'(LW)) || (op == 4'(SW));
        return (half_op && a[0]) || (word_op && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: byte enables, store-data replication and
// load-data extraction with sign/zero extension (little-endian).
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] sdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ldata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be    = 4'b0000;
        wdata = sdata;
        ldata = rdata;
        case (mem_op_e'(op))
            LB: begin
                be    = 4'b0001 << addr_lo;
                ldata = {{24{byte_sel[7]}}, byte_sel};
            end
            LBU: begin
                be    = 4'b0001 << addr_lo;
                ldata = {24'b0, byte_sel};
            end
            LH: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                ldata = {{16{half_sel[15]}}, half_sel};
            end
            LHU: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                ldata = {16'b0, half_sel};
            end
            LW: be = 4'b1111;
            SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            SH: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sdata[15:0]}};
            end
            SW: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: runs loads/stores over a req/ack bus, stalls upstream while
// busy, aborts on timeout. Optional MEM_ALIGN_CHECK_EN adds misalignment traps.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int ADDR_W      = 32,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_sdata_i,
    output logic                  stall_req_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic                  bus_err_o,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  align_exc_o,
    output logic [ADDR_W-1:0]     bad_addr_o
`endif
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(BUS_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  valid_d, wreg_d, err_d, exc_d;
    logic [REG_ADDR_W-1:0] wd_d;
    logic [DATA_W-1:0]     wdata_d;
    logic                  mem_op, misal, in_bus;
    logic [3:0]            lane_be;
    logic [DATA_W-1:0]     lane_wdata, lane_ldata;

    mem_lane_align u_lane (
        .op      (mem_op_i),
        .addr_lo (mem_addr_i[1:0]),
        .sdata   (mem_sdata_i),
        .rdata   (bus_rdata_i),
        .be      (lane_be),
        .wdata   (lane_wdata),
        .ldata   (lane_ldata)
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign misal = is_misaligned(mem_op_i, mem_addr_i[1:0]);
`else
    assign misal = 1'b0;
`endif

    assign mem_op = is_mem(mem_op_i);
    assign in_bus = (state_q == BUS);

    // Bus handshake: bus_req_o stays high with we/addr/be/wdata stable until the
    // cycle bus_ack_i is sampled high; that edge completes the transfer. Any ack
    // seen outside BUS is ignored. Address and lanes come from the held upstream
    // inputs, which the stall keeps constant.
    assign bus_req_o   = in_bus;
    assign bus_we_o    = in_bus & is_store(mem_op_i);
    assign bus_addr_o  = in_bus ? {mem_addr_i[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be_o    = in_bus ? lane_be : 4'b0000;
    assign bus_wdata_o = in_bus ? lane_wdata : '0;

    // Gated by reset so every output reads 0 while rst_i is asserted.
    assign stall_req_o = ~rst_i & (((state_q == IDLE) & valid_i & mem_op & ~misal) |
                                   (in_bus & ~bus_ack_i));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        wreg_d  = 1'b0;
        wd_d    = '0;
        wdata_d = '0;
        err_d   = 1'b0;
        exc_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!mem_op) begin
                        valid_d = 1'b1;
                        wd_d    = wd_i;
                        wreg_d  = wreg_i;
                        wdata_d = wdata_i;
                    end else if (misal) begin
                        exc_d = 1'b1;
                    end else begin
                        state_d = BUS;
                        cnt_d   = '0;
                    end
                end
            end
            BUS: begin
                if (bus_ack_i) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    wdata_d = is_store(mem_op_i) ? wdata_i : lane_ldata;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            valid_o   <= 1'b0;
            wd_o      <= '0;
            wreg_o    <= 1'b0;
            wdata_o   <= '0;
            bus_err_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_o   <= valid_d;
            wd_o      <= wd_d;
            wreg_o    <= wreg_d;
            wdata_o   <= wdata_d;
            bus_err_o <= err_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            align_exc_o <= 1'b0;
            bad_addr_o  <= '0;
        end else begin
            align_exc_o <= exc_d;
            if (exc_d) begin
                bad_addr_o <= mem_addr_i;
            end
        end
    end
`else
    logic unused_exc;
    assign unused_exc = exc_d;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table through a writeback scoreboard, plus
// timeout, reset and alignment sequences.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int REG_ADDR_W = 5;
    localparam int ADDR_W     = 32;
    localparam int TIMEOUT    = 4;
    localparam int WB_W       = REG_ADDR_W + 1 + 32;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  valid_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic [31:0]           wdata_i;
    logic [3:0]            mem_op_i;
    logic [ADDR_W-1:0]     mem_addr_i;
    logic [31:0]           mem_sdata_i;
    logic                  stall_req_o;
    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_W-1:0]     bus_addr_o;
    logic [3:0]            bus_be_o;
    logic [31:0]           bus_wdata_o;
    logic [31:0]           bus_rdata_i;
    logic                  bus_ack_i;
    logic                  bus_err_o;
    logic                  valid_o;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [31:0]           wdata_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic                  align_exc_o;
    logic [ADDR_W-1:0]     bad_addr_o;
`endif

    mem_access_unit #(
        .REG_ADDR_W  (REG_ADDR_W),
        .ADDR_W      (ADDR_W),
        .BUS_TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sdata_i (mem_sdata_i),
        .stall_req_o (stall_req_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .bus_err_o   (bus_err_o),
        .valid_o     (valid_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .align_exc_o (align_exc_o),
        .bad_addr_o  (bad_addr_o)
`endif
    );

    // Clock and reset
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    logic [WB_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid writeback must match the oldest expected entry.
    logic [WB_W-1:0] wb_exp;
    always @(negedge clk_i) begin
        if (!rst_i && valid_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got %0h expected none", {wd_o, wreg_o, wdata_o});
            end else begin
                wb_exp = exp_q.pop_front();
                check("wb_triple", 64'({wd_o, wreg_o, wdata_o}), 64'(wb_exp));
            end
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata,
                                input int delay, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, input logic [3:0] exp_be,
                                input logic [31:0] exp_bwdata, input logic [31:0] exp_wb);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.delay = delay;
        v.wd = wd; v.wreg = wreg; v.wdata = wdata; v.exp_be = exp_be;
        v.exp_bwdata = exp_bwdata; v.exp_wb = exp_wb;
        return v;
    endfunction

    task automatic drive_op(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [4:0] wd,
                            input logic wreg, input logic [31:0] wdata);
        valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata; bus_ack_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic mem;
        logic store;
        mem   = (v.op != 4'(MEM_NONE));
        store = (v.op == 4'(SB)) || (v.op == 4'(SH)) || (v.op == 4'(SW));
        @(posedge clk_i); #1;
        drive_op(v.op, v.addr, v.sdata, v.wd, v.wreg, v.wdata);
        bus_rdata_i = v.rdata;
        @(negedge clk_i);
        check("issue_stall", 64'(stall_req_o), 64'(mem));
        check("issue_no_req", 64'(bus_req_o), 64'(0));
        if (!mem) begin
            exp_q.push_back({v.wd, v.wreg, v.exp_wb});
            @(posedge clk_i); #1;
            valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            for (int k = 0; k <= v.delay; k++) begin
                #1;
                bus_ack_i = (k == v.delay);
                if (k == v.delay) exp_q.push_back({v.wd, v.wreg, v.exp_wb});
                @(negedge clk_i);
                if (k == 0) check("bus_bubble", 64'(valid_o), 64'(0));
                check("bus_req", 64'(bus_req_o), 64'(1));
                check("bus_addr", 64'(bus_addr_o), 64'({v.addr[31:2], 2'b00}));
                check("bus_be", 64'(bus_be_o), 64'(v.exp_be));
                check("bus_we", 64'(bus_we_o), 64'(store));
                if (store) check("bus_wdata", 64'(bus_wdata_o), 64'(v.exp_bwdata));
                check("bus_stall", 64'(stall_req_o), 64'(k != v.delay));
                @(posedge clk_i);
            end
            #1;
            bus_ack_i = 1'b0;
            valid_i   = 1'b0;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        drive_op(4'(LW), 32'h0000_0100, 32'h0, 5'd1, 1'b1, 32'h0);
        bus_rdata_i = 32'h0;

        vecs.push_back(mk(4'(MEM_NONE), 32'h0, 32'h0, 32'h0, 0, 5'd5, 1'b1, 32'h1234, 4'h0, 32'h0, 32'h1234));
        vecs.push_back(mk(4'(LB),  32'h103, 32'h0, 32'h80FF_FF7F, 2, 5'd7, 1'b1, 32'h0, 4'h8, 32'h0, 32'hFFFF_FF80));
        vecs.push_back(mk(4'(LBU), 32'h103, 32'h0, 32'h80FF_FF7F, 2, 5'd8, 1'b1, 32'h0, 4'h8, 32'h0, 32'h0000_0080));
        vecs.push_back(mk(4'(SH),  32'h202, 32'h0000_ABCD, 32'h0, 0, 5'd0, 1'b0, 32'h55, 4'hC, 32'hABCD_ABCD, 32'h55));
        vecs.push_back(mk(4'(LH),  32'h206, 32'h0, 32'h8001_7FFF, 1, 5'd9, 1'b1, 32'h0, 4'hC, 32'h0, 32'hFFFF_8001));
        vecs.push_back(mk(4'(LHU), 32'h204, 32'h0, 32'h8001_F00F, 1, 5'd10, 1'b1, 32'h0, 4'h3, 32'h0, 32'h0000_F00F));
        vecs.push_back(mk(4'(LW),  32'h400, 32'h0, 32'hDEAD_BEEF, 0, 5'd11, 1'b1, 32'h0, 4'hF, 32'h0, 32'hDEAD_BEEF));
        vecs.push_back(mk(4'(SB),  32'h101, 32'h1234_56A5, 32'h0, 1, 5'd0, 1'b0, 32'h77, 4'h2, 32'hA5A5_A5A5, 32'h77));
        vecs.push_back(mk(4'(SW),  32'h408, 32'hCAFE_F00D, 32'h0, 2, 5'd0, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0));
        vecs.push_back(mk(4'(LB),  32'h100, 32'h0, 32'h0000_0012, 0, 5'd12, 1'b1, 32'h0, 4'h1, 32'h0, 32'h0000_0012));
        vecs.push_back(mk(4'(MEM_NONE), 32'h0, 32'h0, 32'h0, 0, 5'd31, 1'b1, 32'h8000_0001, 4'h0, 32'h0, 32'h8000_0001));
`ifndef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk(4'(LW),  32'h301, 32'h0, 32'h1122_3344, 0, 5'd13, 1'b1, 32'h0, 4'hF, 32'h0, 32'h1122_3344));
        vecs.push_back(mk(4'(LH),  32'h203, 32'h0, 32'hF234_5678, 1, 5'd14, 1'b1, 32'h0, 4'hC, 32'h0, 32'hFFFF_F234));
`endif

        // Reset state, with a memory op presented to prove the stall is held low
        #12;
        check("rst_stall", 64'(stall_req_o), 64'(0));
        check("rst_req", 64'(bus_req_o), 64'(0));
        check("rst_outs", 64'({valid_o, wreg_o, wd_o, bus_err_o, bus_be_o}), 64'(0));
        check("rst_wdata", 64'(wdata_o), 64'(0));
        @(posedge clk_i); #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Timeout: no ack, request held for TIMEOUT cycles, then abort
        @(posedge clk_i); #1;
        drive_op(4'(LW), 32'h500, 32'h0, 5'd3, 1'b1, 32'h0);
        @(posedge clk_i);
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk_i);
            check("to_req", 64'(bus_req_o), 64'(1));
            check("to_no_err", 64'(bus_err_o), 64'(0));
            @(posedge clk_i);
        end
        #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        check("to_err", 64'(bus_err_o), 64'(1));
        check("to_bubble", 64'({valid_o, wreg_o}), 64'(0));
        check("to_req_drop", 64'(bus_req_o), 64'(0));
        check("to_stall_rel", 64'(stall_req_o), 64'(0));
        @(negedge clk_i);
        check("to_err_pulse", 64'(bus_err_o), 64'(0));

        // Reset clears a live writeback immediately
        @(posedge clk_i); #1;
        drive_op(4'(MEM_NONE), 32'h0, 32'h0, 5'd9, 1'b1, 32'hBEEF);
        exp_q.push_back({5'd9, 1'b1, 32'hBEEF});
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        check("rst_wb_clear", 64'({valid_o, wreg_o, wd_o}), 64'(0));
        check("rst_wb_data", 64'(wdata_o), 64'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Reset mid-BUS: request drops without a clock edge, late ack ignored
        @(posedge clk_i); #1;
        drive_op(4'(LW), 32'h600, 32'h0, 5'd4, 1'b1, 32'h0);
        bus_rdata_i = 32'h5555_AAAA;
        @(posedge clk_i); #1;
        check("mid_req_up", 64'(bus_req_o), 64'(1));
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_req_drop", 64'(bus_req_o), 64'(0));
        check("mid_outs", 64'({stall_req_o, bus_be_o, bus_we_o, valid_o}), 64'(0));
        check("mid_addr", 64'(bus_addr_o), 64'(0));
        @(posedge clk_i); #1;
        rst_i     = 1'b0;
        valid_i   = 1'b0;
        bus_ack_i = 1'b1;
        @(negedge clk_i);
        check("late_ack_req", 64'(bus_req_o), 64'(0));
        @(posedge clk_i); #1;
        bus_ack_i = 1'b0;
        @(negedge clk_i);
        check("late_ack_wb", 64'({valid_o, wreg_o}), 64'(0));

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word: trap instead of bus access
        @(posedge clk_i); #1;
        drive_op(4'(LW), 32'h301, 32'h0, 5'd6, 1'b1, 32'h0);
        @(negedge clk_i);
        check("al_no_stall", 64'(stall_req_o), 64'(0));
        check("al_no_req", 64'(bus_req_o), 64'(0));
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        check("al_exc", 64'(align_exc_o), 64'(1));
        check("al_bad_addr", 64'(bad_addr_o), 64'(32'h301));
        check("al_bubble", 64'({valid_o, wreg_o}), 64'(0));
        @(negedge clk_i);
        check("al_exc_pulse", 64'(align_exc_o), 64'(0));
        check("al_bad_hold", 64'(bad_addr_o), 64'(32'h301));
`endif

        repeat (2) @(negedge clk_i);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
